// File: rtl/sort_pkg.sv
// Shared definitions for the sorter and the sorted-frame transmitter.
// SORT_WIDTH / SORT_N : default word width and frame length.
// tx_state_t          : transmitter FSM states.
package sort_pkg;

    localparam int SORT_WIDTH = 8;
    localparam int SORT_N     = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/sort_order_check.sv
// Combinational order checker.
// It raises a flag when the frame is not non-decreasing from word 0 to word N-1.
// The compare is unsigned, and equal neighbours are allowed.
// Ports:
//   frame    : N*WIDTH packed frame; word k sits at [k*WIDTH +: WIDTH]
//   unsorted : 1 when some word[k] > word[k+1]
module sort_order_check
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_WIDTH,
    parameter int N     = SORT_N
) (
    input  logic [N*WIDTH-1:0] frame,
    output logic               unsorted
);

    // OR-reduce all adjacent descents
    always_comb begin
        unsorted = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if (frame[k*WIDTH +: WIDTH] > frame[(k+1)*WIDTH +: WIDTH]) begin
                unsorted = 1'b1;
            end else begin
                unsorted = unsorted;
            end
        end
    end

endmodule

// File: rtl/sorted_frame_tx.sv
// Captures a parallel sorted frame and streams it out one word per beat.
// The order is ascending or descending, chosen per frame. The block also reports
// whether the captured frame was really sorted.
// Ports:
//   clk, rst     : clock, async active-high reset
//   frame_in     : N*WIDTH parallel frame (word 0 = sorter out1)
//   desc, load   : order select and frame valid (both sampled at load)
//   frame_ready  : block can accept a frame
//   out_data/out_valid/out_ready/out_last/out_idx : word stream
//   sort_err     : captured frame not non-decreasing (held until next load)
//   done         : one-cycle pulse after the final beat transfers
module sorted_frame_tx
    import sort_pkg::*;
#(
    parameter int WIDTH = SORT_WIDTH,
    parameter int N     = SORT_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   frame_in,
    input  logic                 desc,
    input  logic                 load,
    output logic                 frame_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 sort_err,
    output logic                 done
);

    localparam int CW = $clog2(N);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(N - 1);

    tx_state_t          state_r, state_s;
    logic [N*WIDTH-1:0] frame_buf_r;
    logic [N*WIDTH-1:0] src_s;
    cnt_t               cnt_r, cnt_s, sel_s;
    logic               desc_r, desc_s;
    logic               load_s, xfer_s, unsorted_s;
    logic               frame_ready_r, out_valid_r, out_last_r, sort_err_r, done_r;
    logic [WIDTH-1:0]   out_data_r, word_s;
    cnt_t               out_idx_r;

    sort_order_check #(.WIDTH(WIDTH), .N(N)) u_check (
        .frame    (frame_in),
        .unsorted (unsorted_s)
    );

    // Next-state logic, beat counter, and the word to present after this edge
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        desc_s  = desc_r;
        load_s  = 1'b0;
        xfer_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load && frame_ready_r) begin
                    load_s  = 1'b1;
                    state_s = SEND;
                    cnt_s   = '0;
                    desc_s  = desc;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (out_valid_r && out_ready) begin
                    xfer_s = 1'b1;
                    // The final beat always leaves SEND, so cnt never wraps
                    if (cnt_r == LAST) begin
                        state_s = IDLE;
                    end else begin
                        cnt_s = cnt_r + cnt_t'(1);
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // On the load edge the buffer is not written yet, so take beat 0 from frame_in
        src_s  = load_s ? frame_in : frame_buf_r;
        sel_s  = desc_s ? (LAST - cnt_s) : cnt_s;
        word_s = src_s[int'(sel_s)*WIDTH +: WIDTH];
    end

    // State, buffer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            frame_buf_r   <= '0;
            cnt_r         <= '0;
            desc_r        <= 1'b0;
            frame_ready_r <= 1'b0;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_last_r    <= 1'b0;
            out_idx_r     <= '0;
            sort_err_r    <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            desc_r        <= desc_s;
            frame_ready_r <= (state_s == IDLE);
            out_valid_r   <= (state_s == SEND);
            out_data_r    <= (state_s == SEND) ? word_s : '0;
            out_idx_r     <= (state_s == SEND) ? cnt_s : '0;
            out_last_r    <= (state_s == SEND) && (cnt_s == LAST);
            done_r        <= xfer_s && (cnt_r == LAST);
            if (load_s) begin
                frame_buf_r <= frame_in;
                sort_err_r  <= unsorted_s;
            end else begin
                frame_buf_r <= frame_buf_r;
                sort_err_r  <= sort_err_r;
            end
        end
    end

    assign frame_ready = frame_ready_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_last    = out_last_r;
    assign out_idx     = out_idx_r;
    assign sort_err    = sort_err_r;
    assign done        = done_r;

endmodule

// File: tb/tb_sorted_frame_tx.sv
// Self-checking bench for sorted_frame_tx.
// Directed frames and random frames are compared against a reference model.
// The model gives the expected stream order and the sortedness of each frame.
module tb_sorted_frame_tx;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] frame_in;
    logic           desc, load, out_ready;
    logic           frame_ready, out_valid, out_last, sort_err, done;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_idx;

    int checks = 0;
    int errors = 0;
    int cur_f[N];

    sorted_frame_tx #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst(rst), .frame_in(frame_in), .desc(desc), .load(load),
        .frame_ready(frame_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_idx(out_idx),
        .sort_err(sort_err), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the frame is sorted iff it equals its own ascending sort
    function automatic bit model_err();
        int q[$];
        for (int k = 0; k < N; k++) q.push_back(cur_f[k]);
        q.sort();
        for (int k = 0; k < N; k++) if (q[k] != cur_f[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic pack_frame();
        for (int k = 0; k < N; k++) frame_in[k*W +: W] = W'(cur_f[k]);
    endtask

    task automatic rand_frame(input bit sorted, input int maxv);
        int q[$];
        for (int k = 0; k < N; k++) q.push_back(int'($urandom_range(0, maxv)));
        if (sorted) q.sort();
        for (int k = 0; k < N; k++) cur_f[k] = q[k];
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_frame_ready"}, frame_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_sort_err"}, sort_err, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready
    task automatic send_frame(input bit d, input int mode, input bit busy);
        int  t, b, cyc;
        bit  rdy, err;
        int  exp_w[$];
        t = 0;
        while (!frame_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("frame_ready_before_load", frame_ready, 1);
        err = model_err();
        for (int k = 0; k < N; k++) exp_w.push_back(d ? cur_f[N-1-k] : cur_f[k]);
        pack_frame();
        desc = d;
        load = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        frame_in = {$urandom, $urandom};
        desc     = 1'($urandom_range(0, 1));
        chk("frame_ready_after_load", frame_ready, 0);
        b   = 0;
        cyc = 0;
        while (b < N && cyc < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (busy && cyc == 2) begin
                load     = 1'b1;
                frame_in = {$urandom, $urandom};
            end else begin
                load = 1'b0;
            end
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, exp_w[b]);
            chk("out_idx", out_idx, b);
            chk("out_last", out_last, (b == N - 1));
            chk("sort_err", sort_err, err);
            chk("done_mid", done, 0);
            chk("frame_ready_busy", frame_ready, 0);
            @(negedge clk);
            cyc++;
            if (rdy) b++;
        end
        load      = 1'b0;
        out_ready = 1'b0;
        chk("beats_transferred", b, N);
        if (mode == 0) chk("cycles_no_stall", cyc, N);
        chk("done_pulse", done, 1);
        chk("frame_ready_after_done", frame_ready, 1);
        chk("out_valid_after_done", out_valid, 0);
        chk("sort_err_hold", sort_err, err);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        out_ready = 1'b0;
        desc      = 1'b0;
        frame_in  = '0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        chk("frame_ready_pre_edge", frame_ready, 0);
        @(negedge clk);
        chk("frame_ready_first_edge", frame_ready, 1);

        // Ascending, descending and backpressure on the reference frame
        cur_f = '{3, 5, 9, 12, 20, 40, 41, 255};
        send_frame(1'b0, 0, 1'b0);
        send_frame(1'b1, 0, 1'b0);
        send_frame(1'b0, 1, 1'b0);

        // Unsorted frame, then a sorted frame with duplicates clears the flag
        cur_f = '{1, 2, 2, 7, 6, 8, 9, 10};
        send_frame(1'b0, 0, 1'b0);
        cur_f = '{1, 2, 2, 7, 7, 8, 9, 10};
        send_frame(1'b1, 1, 1'b0);

        // Load attempt while busy must be ignored
        rand_frame(1'b1, 255);
        send_frame(1'b0, 0, 1'b1);

        // Reset after beat 3
        cur_f = '{10, 20, 30, 40, 50, 60, 70, 80};
        pack_frame();
        desc = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_reset_idx", out_idx, 4);
        chk("pre_reset_data", out_data, 50);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        chk("reset_hold_done", done, 0);
        chk("reset_hold_valid", out_valid, 0);
        rst       = 1'b0;
        out_ready = 1'b0;
        chk("release_frame_ready", frame_ready, 0);
        @(negedge clk);
        chk("release_frame_ready_edge", frame_ready, 1);
        chk("release_no_done", done, 0);
        rand_frame(1'b1, 255);
        send_frame(1'b1, 0, 1'b0);

        // Random frames: mixed sortedness, small ranges for duplicates, random ready
        for (int i = 0; i < 20; i++) begin
            rand_frame(1'($urandom_range(0, 1)), (i % 2 == 0) ? 7 : 255);
            send_frame(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sorted_frame_tx.md
# sorted_frame_tx

Streams one sorted frame out as single words. The block captures a parallel frame of N words from the combinational sorter's registered outputs, then sends the words one per beat over a valid/ready stream. The order is ascending or descending, selectable per frame. It also checks whether the captured frame is actually sorted and reports the result.

## Interface
- `WIDTH`, default 8: bits per word.
- `N`, default 8: words per frame. Must be ≥ 2.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `frame_in`  in  N*WIDTH: parallel frame. Word k sits at `[k*WIDTH +: WIDTH]`. Word 0 maps to sorter `out1`.
- `desc`  in  1: transmit order, sampled at load. 0 sends word 0 first; 1 sends word N-1 first.
- `load`  in  1: frame valid.
- `frame_ready`  out  1: block can accept a frame.
- `out_data`  out  WIDTH: current word.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: downstream accepts the word.
- `out_last`  out  1: current beat is the final word of the frame.
- `out_idx`  out  $clog2(N): position of the current beat within the stream, 0..N-1.
- `sort_err`  out  1: the captured frame is not non-decreasing from word 0 to word N-1.
- `done`  out  1: one-cycle pulse when a frame completes.

## Operation
- States:
  - `IDLE`: `frame_ready`=1.
  - `SEND`: beats in flight.
- Load: `load && frame_ready` at a clk edge.
  - Copies `frame_in` into an internal N×WIDTH buffer.
  - Latches `desc`.
  - Sets the beat counter to 0.
  - Goes to `SEND`.
  - `load` is ignored while `frame_ready`=0.
- Word selection in `SEND`:
  - `out_data` = buffer[cnt] when `desc`=0, buffer[N-1-cnt] when `desc`=1.
  - `out_idx` = cnt.
  - `out_last` = (cnt == N-1).
- Handshake: a beat transfers on an edge where `out_valid && out_ready`.
  - After a transfer, cnt increments.
  - A transfer with `out_last`=1 returns the block to `IDLE`.
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_idx` and `out_last` hold stable.
  - `out_valid` never drops before its beat transfers.
- Order check, evaluated on `frame_in` at load:
  - `sort_err` is set if any pair has word[k] > word[k+1], for k in 0..N-2. Comparison is unsigned.
  - Equal neighbours are legal.
  - `sort_err` is registered at load and holds until the next load.
  - `desc` does not affect the check.
- `done` pulses for exactly one cycle, the cycle after the final beat transfers.
- Counter width is $clog2(N). The counter never wraps mid-frame, because the final beat always leaves `SEND`.

## Timing
- Reset values: `frame_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `out_idx`=0, `sort_err`=0, `done`=0. Buffer is cleared to 0.
- State after reset is `IDLE`. `frame_ready` rises on the first clk edge after `rst` deasserts.
- Latency:
  - Load edge L gives `out_valid`=1 with beat 0 from edge L.
  - With `out_ready` held high, beat k appears after edge L+k.
  - The final beat transfers at edge L+N. `done`=1 and `frame_ready`=1 after that edge.
  - Minimum frame period is N+1 cycles.
- A `load` in the same cycle as the final transfer is not accepted, because `frame_ready`=0.
- `rst` asserted mid-frame:
  - Outputs go to reset values immediately, asynchronously.
  - The partial frame is discarded and no `done` pulse is produced.
- `frame_in` may change freely after the load edge.

## Structure
- Shared package `sort_pkg`:
  - `SORT_WIDTH`=8 and `SORT_N`=8, also used by the sorter.
  - State enum `tx_state_t` {`IDLE`, `SEND`}.
- Sub-module `sort_order_check`:
  - Combinational.
  - Input: N*WIDTH frame. Output: 1-bit unsorted flag.
  - Reusable as a checker behind the sorter.
- Top level contains the FSM, buffer, counter and output mux.

## Test plan
- Ascending send: frame {3,5,9,12,20,40,41,255}, `desc`=0, `out_ready`=1.
  - Beats are 3,5,…,255 on 8 consecutive cycles, with `out_idx` 0..7.
  - `out_last` is high only on 255.
  - `sort_err`=0; `done` pulses once.
- Descending send: same frame, `desc`=1.
  - Beats are 255,41,40,20,12,9,5,3.
- Backpressure: `out_ready` toggles 1,0,0,1,…
  - No beat is lost or duplicated.
  - `out_data` stays stable through stall cycles.
  - Total of 8 transfers.
- Unsorted frame {1,2,2,7,6,8,9,10}:
  - `sort_err`=1 after the load and throughout the frame.
  - The next load of a sorted frame clears it.
  - Duplicate 2,2 alone does not set the flag.
- Load while busy: pulse `load` with a different frame during `SEND`.
  - The frame is ignored and the original 8 words are sent.
  - The next frame is accepted only after `done`.
- Reset mid-frame: assert `rst` after beat 3.
  - All outputs are 0 immediately and no `done` pulse occurs.
  - After release, `frame_ready` rises one edge later and a fresh frame sends correctly.
